// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
//   Shared definitions for the voice allocator slice.
//   - va_state_e    : allocator FSM encodings (VA_IDLE, VA_SCAN, VA_ISSUE)
//   - VOICE_ENTRY_W : width of one slot-table entry (note 7 + channel 4 + busy 1)
//   - voice_entry_t : packed view of a slot-table entry, busy in bit 0
// -----------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [1:0] {
        VA_IDLE  = 2'd0,
        VA_SCAN  = 2'd1,
        VA_ISSUE = 2'd2
    } va_state_e;

    localparam int VOICE_ENTRY_W = 12;

    typedef struct packed {
        logic [6:0] note;
        logic [3:0] chan;
        logic       busy;
    } voice_entry_t;

endpackage

// File: rtl/voice_table.sv
// -----------------------------------------------------------------------------
// voice_table
//   Slot table of the voice allocator: one entry (note, channel, busy) per slot.
//   Ports:
//     clk32, rst      clock, synchronous active-high reset (clears every slot)
//     rd_idx_i        slot index for the combinational read port
//     rd_entry_o      entry stored at rd_idx_i
//     wr_en_i         write strobe
//     wr_addr_i       slot index to write
//     wr_entry_i      entry to store (bit 0 = busy)
//     busy_count_o    number of busy slots
// -----------------------------------------------------------------------------
module voice_table
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 128,
    parameter int IDX_W      = 7
) (
    input  logic                     clk32,
    input  logic                     rst,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [VOICE_ENTRY_W-1:0] rd_entry_o,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_addr_i,
    input  logic [VOICE_ENTRY_W-1:0] wr_entry_i,
    output logic [7:0]               busy_count_o
);

    logic [VOICE_ENTRY_W-1:0] entries_q [NUM_VOICES];
    logic [7:0]               count_q;
    logic                     old_busy;
    logic                     new_busy;

    assign rd_entry_o   = entries_q[rd_idx_i];
    assign busy_count_o = count_q;

    // The counter only moves on a busy-bit transition, so rewriting a busy
    // slot with new note/channel (a steal) leaves the count unchanged.
    assign old_busy = entries_q[wr_addr_i][0];
    assign new_busy = wr_entry_i[0];

    always_ff @(posedge clk32) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else if (wr_en_i) begin
            entries_q[wr_addr_i] <= wr_entry_i;
            if (new_busy && !old_busy) begin
                count_q <= count_q + 8'd1;
            end else if (!new_busy && old_busy) begin
                count_q <= count_q - 8'd1;
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// -----------------------------------------------------------------------------
// voice_alloc
//   Maps MIDI note-on/off events to voice slots and emits one-cycle
//   press/release/drop strobes with note, velocity, channel and slot address.
//   Ports:
//     clk32, rst        32 MHz clock, synchronous active-high reset
//     ev_valid/ev_ready event handshake (see below)
//     ev_on, ev_note, ev_vel, ev_chan   event payload
//     note_pressed, note_released, drop_evt   one-cycle strobes
//     note_keypress     always 0
//     note, velocity, channel, addr   payload of the strobed event
//     busy_count        number of busy slots
//     dbg_state         current FSM state (va_state_e encoding)
//   Build option: define VOICE_STEAL_EN to steal slots round-robin when the
//   table is full; otherwise a full note-on pulses drop_evt.
//
//   Handshake: an event transfers on a rising clk32 edge where ev_valid and
//   ev_ready are both high. ev_ready is high only in IDLE; the producer must
//   hold ev_valid and payload stable until the transfer.
//
//   Timing: accept in cycle 0, SCAN in cycles 1..NUM_VOICES (one slot each),
//   ISSUE in cycle NUM_VOICES+1, strobe and ev_ready in cycle NUM_VOICES+2.
// -----------------------------------------------------------------------------
module voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 128,
    parameter int ADDR_W     = 8
) (
    input  logic              clk32,
    input  logic              rst,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [6:0]        ev_note,
    input  logic [6:0]        ev_vel,
    input  logic [3:0]        ev_chan,
    output logic              note_pressed,
    output logic              note_released,
    output logic              note_keypress,
    output logic [6:0]        note,
    output logic [6:0]        velocity,
    output logic [3:0]        channel,
    output logic [ADDR_W-1:0] addr,
    output logic              drop_evt,
    output logic [7:0]        busy_count,
    output logic [1:0]        dbg_state
);

    localparam int               IDX_W    = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    va_state_e          state_q;
    logic               ev_ready_q;
    logic               ev_on_q;
    logic [6:0]         ev_note_q;
    logic [6:0]         ev_vel_q;
    logic [3:0]         ev_chan_q;
    logic [IDX_W-1:0]   idx_q;
    logic               match_found_q;
    logic [IDX_W-1:0]   match_idx_q;
    logic               free_found_q;
    logic [IDX_W-1:0]   free_idx_q;
    logic               pressed_q;
    logic               released_q;
    logic               drop_q;
    logic [6:0]         note_q;
    logic [6:0]         vel_q;
    logic [3:0]         chan_q;
    logic [ADDR_W-1:0]  addr_q;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]   steal_ptr_q;
`endif

    logic                     press_d;
    logic                     release_d;
    logic                     drop_d;
    logic [IDX_W-1:0]         tgt_idx_d;
    logic                     wr_en;
    logic                     wr_busy;
    logic [VOICE_ENTRY_W-1:0] wr_entry;
    logic [VOICE_ENTRY_W-1:0] rd_entry;
    voice_entry_t             rd_e;

    assign rd_e     = voice_entry_t'(rd_entry);
    assign wr_entry = {ev_note_q, ev_chan_q, wr_busy};

    voice_table #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk32        (clk32),
        .rst          (rst),
        .rd_idx_i     (idx_q),
        .rd_entry_o   (rd_entry),
        .wr_en_i      (wr_en),
        .wr_addr_i    (tgt_idx_d),
        .wr_entry_i   (wr_entry),
        .busy_count_o (busy_count)
    );

    // ISSUE decision. A retrigger presses the matched slot without touching
    // the table; a release clears busy on the matched slot.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        drop_d    = 1'b0;
        tgt_idx_d = '0;
        wr_en     = 1'b0;
        wr_busy   = 1'b0;
        if (state_q == VA_ISSUE) begin
            if (ev_on_q) begin
                if (match_found_q) begin
                    press_d   = 1'b1;
                    tgt_idx_d = match_idx_q;
                end else if (free_found_q) begin
                    press_d   = 1'b1;
                    tgt_idx_d = free_idx_q;
                    wr_en     = 1'b1;
                    wr_busy   = 1'b1;
                end else begin
`ifdef VOICE_STEAL_EN
                    press_d   = 1'b1;
                    tgt_idx_d = steal_ptr_q;
                    wr_en     = 1'b1;
                    wr_busy   = 1'b1;
`else
                    drop_d    = 1'b1;
`endif
                end
            end else if (match_found_q) begin
                release_d = 1'b1;
                tgt_idx_d = match_idx_q;
                wr_en     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q       <= VA_IDLE;
            ev_ready_q    <= 1'b0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            ev_chan_q     <= '0;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            pressed_q     <= 1'b0;
            released_q    <= 1'b0;
            drop_q        <= 1'b0;
            note_q        <= '0;
            vel_q         <= '0;
            chan_q        <= '0;
            addr_q        <= '0;
`ifdef VOICE_STEAL_EN
            steal_ptr_q   <= '0;
`endif
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                VA_IDLE: begin
                    ev_ready_q <= 1'b1;
                    if (ev_valid && ev_ready_q) begin
                        ev_ready_q    <= 1'b0;
                        // note-on with velocity 0 is a note-off
                        ev_on_q       <= ev_on && (ev_vel != 7'd0);
                        ev_note_q     <= ev_note;
                        ev_vel_q      <= ev_vel;
                        ev_chan_q     <= ev_chan;
                        idx_q         <= '0;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        state_q       <= VA_SCAN;
                    end
                end
                VA_SCAN: begin
                    if (!match_found_q && rd_e.busy &&
                        rd_e.note == ev_note_q && rd_e.chan == ev_chan_q) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= idx_q;
                    end
                    if (!free_found_q && !rd_e.busy) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= VA_ISSUE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                VA_ISSUE: begin
                    state_q    <= VA_IDLE;
                    ev_ready_q <= 1'b1;
                    pressed_q  <= press_d;
                    released_q <= release_d;
                    drop_q     <= drop_d;
                    note_q     <= ev_note_q;
                    vel_q      <= ev_vel_q;
                    chan_q     <= ev_chan_q;
                    addr_q     <= ADDR_W'(tgt_idx_d);
`ifdef VOICE_STEAL_EN
                    if (ev_on_q && !match_found_q && !free_found_q) begin
                        steal_ptr_q <= (steal_ptr_q == LAST_IDX) ? '0 : steal_ptr_q + 1'b1;
                    end
`endif
                end
                default: state_q <= VA_IDLE;
            endcase
        end
    end

    assign ev_ready      = ev_ready_q;
    assign note_pressed  = pressed_q;
    assign note_released = released_q;
    assign drop_evt      = drop_q;
    assign note_keypress = 1'b0;
    assign note          = note_q;
    assign velocity      = vel_q;
    assign channel       = chan_q;
    assign addr          = addr_q;
    assign dbg_state     = state_q;

endmodule
